// File: rtl/assert_seq_gen.sv
// assert_seq_gen: emits a->b->c->d bursts (reps x, gap idle cycles apart).
// Ports: clock, reset(async hi), start, gap, reps, [inj_en, inj_step with
// ASSERT_SEQ_ERR_INJ_EN], a..d pattern, e end marker, busy, done, iter_cnt.
module assert_seq_gen #(
  parameter int GAP_W = 4,
  parameter int REP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef ASSERT_SEQ_ERR_INJ_EN
  input  logic             inj_en,
  input  logic [1:0]       inj_step,
`endif
  input  logic [GAP_W-1:0] gap,
  input  logic [REP_W-1:0] reps,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE, S_A, S_B, S_C, S_D, GAP, DONE
  } state_t;

  state_t           state, nstate;
  logic [GAP_W-1:0] gap_q, ngap;
  logic [REP_W-1:0] reps_q, nreps;
  logic [GAP_W-1:0] gcnt, ngcnt;
  logic [REP_W-1:0] niter;
  // last: the iteration in flight is the final one of the burst
  logic             last, nlast;
  logic [3:0]       mask;

`ifdef ASSERT_SEQ_ERR_INJ_EN
  logic       inj_en_q, n_inj_en;
  logic [1:0] inj_step_q, n_inj_step;
`endif

  always_comb begin
    nstate = state;
    ngap   = gap_q;
    nreps  = reps_q;
    ngcnt  = gcnt;
    nlast  = last;
    niter  = iter_cnt;
`ifdef ASSERT_SEQ_ERR_INJ_EN
    n_inj_en   = inj_en_q;
    n_inj_step = inj_step_q;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          niter = '0;
          if (reps != '0) begin
            nstate = S_A;
            ngap   = gap;
            nreps  = reps;
            nlast  = (reps == REP_W'(1));
`ifdef ASSERT_SEQ_ERR_INJ_EN
            n_inj_en   = inj_en;
            n_inj_step = inj_step;
`endif
          end else begin
            nstate = DONE;
          end
        end
      end
      S_A: nstate = S_B;
      S_B: nstate = S_C;
      S_C: nstate = S_D;
      S_D: begin
        niter = iter_cnt + REP_W'(1);
        if (last) begin
          nstate = DONE;
        end else begin
          // next iteration is final when two more completions reach reps
          nlast = ({1'b0, iter_cnt} + (REP_W+1)'(2))
                  == {1'b0, reps_q};
          ngcnt = gap_q;
          nstate = (gap_q == '0) ? S_A : GAP;
        end
      end
      GAP: begin
        if (gcnt <= GAP_W'(1)) nstate = S_A;
        else ngcnt = gcnt - GAP_W'(1);
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
`ifdef ASSERT_SEQ_ERR_INJ_EN
    if (n_inj_en && nlast) mask = 4'b0001 << n_inj_step;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gap_q    <= '0;
      reps_q   <= '0;
      gcnt     <= '0;
      last     <= 1'b0;
      iter_cnt <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      c        <= 1'b0;
      d        <= 1'b0;
      e        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nstate;
      gap_q    <= ngap;
      reps_q   <= nreps;
      gcnt     <= ngcnt;
      last     <= nlast;
      iter_cnt <= niter;
      // outputs decode the state being entered, so they are registered
      a    <= (nstate == S_A) && !mask[0];
      b    <= (nstate == S_B) && !mask[1];
      c    <= (nstate == S_C) && !mask[2];
      d    <= (nstate == S_D) && !mask[3];
      e    <= (nstate == S_D) && nlast;
      busy <= nstate inside {S_A, S_B, S_C, S_D, GAP};
      done <= (nstate == DONE);
    end
  end

`ifdef ASSERT_SEQ_ERR_INJ_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inj_en_q   <= 1'b0;
      inj_step_q <= 2'd0;
    end else begin
      inj_en_q   <= n_inj_en;
      inj_step_q <= n_inj_step;
    end
  end
`endif

endmodule

// File: tb/tb_assert_seq_gen.sv
// tb_assert_seq_gen: randomized self-checking bench for assert_seq_gen.
// Expected waveforms come from a per-cycle schedule model of each burst.
module tb_assert_seq_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] gap   = '0;
  logic [7:0] reps  = '0;
`ifdef ASSERT_SEQ_ERR_INJ_EN
  logic       inj_en   = 1'b0;
  logic [1:0] inj_step = '0;
`endif
  logic       a, b, c, d, e, busy, done;
  logic [7:0] iter_cnt;

  int errors = 0;
  int checks = 0;

  assert_seq_gen #(.GAP_W(4), .REP_W(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
`ifdef ASSERT_SEQ_ERR_INJ_EN
    .inj_en   (inj_en),
    .inj_step (inj_step),
`endif
    .gap      (gap),
    .reps     (reps),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .busy     (busy),
    .done     (done),
    .iter_cnt (iter_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {a,b,c,d,e,busy,done} for cycle t after the start edge.
  function automatic logic [6:0] model_out(
    input int r, input int g, input bit ie, input int is, input int t);
    int p, total, k, s;
    logic [6:0] v;
    v = '0;
    p = 4 + g;
    total = (r == 0) ? 0 : (r - 1) * p + 4;
    if (t <= total) begin
      k = (t - 1) / p;
      s = (t - 1) % p;
      v[1] = 1'b1;
      if (s < 4) begin
        v[6 - s] = 1'b1;
`ifdef ASSERT_SEQ_ERR_INJ_EN
        if (ie && k == r - 1 && s == is) v[6 - s] = 1'b0;
`endif
        if (s == 3 && k == r - 1) v[2] = 1'b1;
      end
    end else if (t == total + 1) begin
      v[0] = 1'b1;
    end
    if (ie && is > 3) v = '0;
    return v;
  endfunction

  // Iterations whose d cycle has already ended before cycle t.
  function automatic int model_iter(input int r, input int g, input int t);
    int n;
    n = 0;
    for (int j = 0; j < r; j++)
      if (j * (4 + g) + 4 < t) n++;
    return n;
  endfunction

  task automatic run_burst(input int r, input int g, input bit ie,
                           input int is, input int extra,
                           input string nm);
    int total;
    logic [6:0] exp, got;
    total = (r == 0) ? 0 : (r - 1) * (4 + g) + 4;
    start = 1'b1;
    reps  = 8'(r);
    gap   = 4'(g);
`ifdef ASSERT_SEQ_ERR_INJ_EN
    inj_en   = ie;
    inj_step = 2'(is);
`endif
    @(posedge clock);
    for (int t = 1; t <= total + 2; t++) begin
      @(negedge clock);
      exp = model_out(r, g, ie, is, t);
      got = {a, b, c, d, e, busy, done};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s t=%0d abcde_busy_done got=%b exp=%b",
                 nm, t, got, exp);
      end
      if (r != 0) begin
        checks++;
        if (iter_cnt !== 8'(model_iter(r, g, t))) begin
          errors++;
          $display("FAIL %s t=%0d iter_cnt got=%0d exp=%0d",
                   nm, t, iter_cnt, model_iter(r, g, t));
        end
      end
      if (t == 1) begin
        start = 1'b0;
        reps  = 8'($urandom);
        gap   = 4'($urandom);
`ifdef ASSERT_SEQ_ERR_INJ_EN
        inj_en   = 1'($urandom);
        inj_step = 2'($urandom);
`endif
      end
      if (t == extra) start = 1'b1;
      else if (t == extra + 1) start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({a, b, c, d, e, busy, done, iter_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0",
               {a, b, c, d, e, busy, done, iter_cnt});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({a, b, c, d, e, busy, done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_release got=%b exp=0",
               {a, b, c, d, e, busy, done});
    end
  endtask

  task automatic test_single;
    repeat (3) @(negedge clock);
    run_burst(1, 5, 1'b0, 0, 0, "single");
  endtask

  task automatic test_back_to_back;
    run_burst(3, 0, 1'b0, 0, 0, "b2b_first");
    run_burst(3, 0, 1'b0, 0, 0, "b2b_second");
  endtask

  task automatic test_gap_ignored_start;
    // t=9 is the second S_B with gap 3
    run_burst(2, 3, 1'b0, 0, 9, "gap_ignored_start");
  endtask

  task automatic test_zero_reps;
    run_burst(0, 2, 1'b0, 0, 0, "zero_reps");
  endtask

  task automatic test_reset_mid_burst;
    start = 1'b1;
    reps  = 8'd3;
    gap   = 4'd2;
    @(posedge clock);
    for (int t = 1; t <= 9; t++) begin
      @(negedge clock);
      start = 1'b0;
    end
    checks++;
    if ({a, b, c, d, busy} !== 5'b00101) begin
      errors++;
      $display("FAIL mid_burst_pre got=%b exp=00101", {a, b, c, d, busy});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a, b, c, d, e, busy, done, iter_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL mid_burst_reset got=%b exp=0",
               {a, b, c, d, e, busy, done, iter_cnt});
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({a, b, c, d, e, busy, done, iter_cnt} !== 15'd0) begin
      errors++;
      $display("FAIL mid_burst_idle got=%b exp=0",
               {a, b, c, d, e, busy, done, iter_cnt});
    end
    run_burst(2, 1, 1'b0, 0, 0, "restart_after_reset");
  endtask

  task automatic test_injection;
    run_burst(2, 1, 1'b1, 2, 0, "inject_c");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_burst(int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
                1'($urandom), int'($urandom_range(0, 3)), 0, "random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap_ignored_start();
    test_zero_reps();
    test_reset_mid_burst();
    test_injection();
    test_random();
    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
